// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, FSM state encoding and the
// data value returned with an aborted transfer.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  // Read data reported for writes and for transfers aborted by timeout.
  localparam logic [WB_DAT_W-1:0] WB_ERR_DAT = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_single_master.sv
// Wishbone B4 classic single-transfer initiator.
// Takes one command at a time on a valid/ready command port, runs it as a
// single classic cycle on the bus, and returns data/completion on a
// valid/ready response port. All outputs except cmd_ready are registered;
// cmd_ready is decoded from the state register alone.
//
// Optional feature: define WB_SINGLE_MASTER_TIMEOUT_EN to abort a bus
// cycle that has not been acked after TIMEOUT_CYCLES cycles (rsp_err=1).
// Without it the bus waits for ack indefinitely and rsp_err is tied low.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | cmd_ready high, waiting for a command
// BUS   | cyc/stb asserted, bus outputs frozen, waiting for ack (or timeout)
// RESP  | rsp_valid high, response fields held until rsp_ready
module wb_single_master
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [WB_ADR_W-1:0] cmd_adr,
  input  logic [WB_DAT_W-1:0] cmd_dat,
  input  logic [WB_SEL_W-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WB_DAT_W-1:0] rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [WB_SEL_W-1:0] wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  output logic [WB_DAT_W-1:0] wbm_dat_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i
);

  // The wait counter is 16 bits wide, so larger limits cannot be honoured.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_single_master: TIMEOUT_CYCLES must be within 1..65535");
  end

  wb_state_e             state_q, state_d;
  logic                  cyc_d, stb_d, we_d;
  logic [WB_SEL_W-1:0]   sel_d;
  logic [WB_ADR_W-1:0]   adr_d;
  logic [WB_DAT_W-1:0]   dat_d;
  logic                  rsp_valid_d;
  logic [WB_DAT_W-1:0]   rsp_dat_d;

`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        rsp_err_d;
`endif

  // Commands are only taken while idle; no input feeds this path.
  assign cmd_ready = (state_q == IDLE);

  // State register and all registered bus/response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      state_q   <= state_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= stb_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
    end
  end

`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
  // Wait counter and error flag exist only when the timeout is built in.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
      rsp_err    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rsp_err    <= rsp_err_d;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_d     = state_q;
    cyc_d       = wbm_cyc_o;
    stb_d       = wbm_stb_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    rsp_err_d   = rsp_err;
`endif

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          state_d = BUS;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end

      BUS: begin
        if (wbm_ack_i) begin
          // An ack always completes normally, even on the timeout cycle.
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = wbm_we_o ? WB_ERR_DAT : wbm_dat_i;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
        else if (wait_cnt_q == WAIT_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_dat_d   = WB_ERR_DAT;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_single_master.sv
// Self-checking bench for wb_single_master. A behavioural Wishbone slave
// with selectable ack styles sits on the bus; expected results come from a
// word-addressed memory model updated in command order.
module tb_wb_single_master;

  localparam int T_CYC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int checks = 0;
  int errors = 0;

  // Slave behaviour: 0 = same-cycle ack, 1 = registered ack, 3 = ack once
  // stb has been high for ack_at+1 cycles.
  int          mode = 0;
  int          ack_at = 1000;
  int          cur_len;
  logic        ack_reg;
  logic        mem_load;
  logic [31:0] slv_mem  [16];
  logic [31:0] init_mem [16];
  logic [31:0] model_mem[16];

  int   stb_cycles = 0;
  int   ack_count = 0;
  logic prev_ack = 1'b0;

  always #5 clk = ~clk;

  wb_single_master #(.TIMEOUT_CYCLES(T_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  assign wbm_ack_i = (mode == 0) ? (wbm_cyc_o & wbm_stb_o) :
                     (mode == 1) ? ack_reg :
                     (wbm_cyc_o & wbm_stb_o & (cur_len == ack_at));
  assign wbm_dat_i = slv_mem[wbm_adr_o[5:2]];

  // Slave: memory writes on ack, registered-ack generation, stb length.
  always @(posedge clk) begin
    if (mem_load) slv_mem <= init_mem;
    if (reset) begin
      ack_reg <= 1'b0;
      cur_len <= 0;
    end else begin
      ack_reg <= (mode == 1) && wbm_cyc_o && wbm_stb_o && !ack_reg;
      cur_len <= (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) ? cur_len + 1 : 0;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i && wbm_we_o)
        slv_mem[wbm_adr_o[5:2]] <= merge(slv_mem[wbm_adr_o[5:2]], wbm_dat_o, wbm_sel_o);
    end
  end

  // Bus monitor: counts strobe cycles and acks, flags stb after an ack.
  always @(posedge clk) begin
    if (reset) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) begin
        checks++;
        if (wbm_stb_o !== 1'b0) begin
          errors++;
          $display("FAIL stb_after_ack: stb=%b required 0 at %0t", wbm_stb_o, $time);
        end
      end
      if (wbm_stb_o) stb_cycles++;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) ack_count++;
      prev_ack = wbm_cyc_o && wbm_stb_o && wbm_ack_i;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [3:0] idx,
                       input logic [31:0] dat, input logic [3:0] sel);
    logic acc;
    logic done;
    done = 1'b0;
    cmd_we = we;
    cmd_adr = 32'h3000_0000 | {26'd0, idx, 2'b00};
    cmd_dat = dat;
    cmd_sel = sel;
    cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) done = 1'b1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL issue_accept: command not accepted within 20 cycles");
    end
  endtask

  task automatic wait_rsp(input int bound, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < bound) begin
      tick();
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: no response within %0d cycles", bound);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b required 0", rsp_err); end
    checks++; if (rsp_dat !== 32'h0) begin errors++; $display("FAIL reset_rsp_dat: got %h required 0", rsp_dat); end
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b000) begin errors++; $display("FAIL reset_cyc_stb_we: got %b required 000", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    checks++; if (wbm_sel_o !== 4'h0) begin errors++; $display("FAIL reset_sel: got %h required 0", wbm_sel_o); end
    checks++; if (wbm_adr_o !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h required 0", wbm_adr_o); end
    checks++; if (wbm_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h required 0", wbm_dat_o); end
    reset = 1'b0;
    mem_load = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait;
    int s0, a0;
    mode = 0;
    rsp_ready = 1'b1;
    s0 = stb_cycles;
    a0 = ack_count;
    cmd_we = 1'b1; cmd_adr = 32'h3000_0000; cmd_dat = 32'h1234_5678; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    model_mem[0] = merge(model_mem[0], 32'h1234_5678, 4'hF);
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111) begin errors++; $display("FAIL wr_bus_ctl: got %b required 111", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
    checks++; if (wbm_adr_o !== 32'h3000_0000) begin errors++; $display("FAIL wr_bus_adr: got %h required 30000000", wbm_adr_o); end
    checks++; if (wbm_dat_o !== 32'h1234_5678) begin errors++; $display("FAIL wr_bus_dat: got %h required 12345678", wbm_dat_o); end
    checks++; if (wbm_sel_o !== 4'hF) begin errors++; $display("FAIL wr_bus_sel: got %h required f", wbm_sel_o); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready_bus: got %b required 0", cmd_ready); end
    tick();
    checks++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin errors++; $display("FAIL wr_drop_stb: got %b required 00", {wbm_cyc_o, wbm_stb_o}); end
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_rsp_valid: got %b required 1", rsp_valid); end
    checks++; if (rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin errors++; $display("FAIL wr_rsp_fields: got dat=%h err=%b required 0/0", rsp_dat, rsp_err); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL wr_cmd_ready_resp: got %b required 0", cmd_ready); end
    tick();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr_back_idle: got rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready); end
    checks++; if (stb_cycles - s0 != 1 || ack_count - a0 != 1) begin errors++; $display("FAIL wr_one_transfer: got stb=%0d ack=%0d required 1/1", stb_cycles - s0, ack_count - a0); end
  endtask

  task automatic test_read_registered;
    int s0, a0, lat;
    mode = 1;
    rsp_ready = 1'b1;
    s0 = stb_cycles;
    a0 = ack_count;
    issue(1'b0, 4'd4, 32'h0, 4'hF);
    wait_rsp(10, lat);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d required 2", lat); end
    checks++; if (rsp_dat !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin errors++; $display("FAIL rd_data: got dat=%h err=%b required cafef00d/0", rsp_dat, rsp_err); end
    tick();
    tick();
    checks++; if (stb_cycles - s0 != 2) begin errors++; $display("FAIL rd_stb_len: got %0d required 2", stb_cycles - s0); end
    checks++; if (ack_count - a0 != 1) begin errors++; $display("FAIL rd_ack_count: got %0d required 1", ack_count - a0); end
  endtask

  task automatic test_backpressure;
    int s0, lat;
    logic [3:0]  idx;
    logic [31:0] exp_d;
    mode = 1;
    rsp_ready = 1'b0;
    idx = 4'($urandom_range(0, 15));
    exp_d = model_mem[idx];
    s0 = stb_cycles;
    issue(1'b0, idx, 32'h0, 4'hF);
    wait_rsp(10, lat);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = (i % 2 == 0);
      cmd_we = 1'b1;
      cmd_adr = $urandom;
      cmd_dat = $urandom;
      cmd_sel = 4'hF;
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== exp_d || cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b dat=%h cmd_ready=%b cyc=%b required 1/%h/0/0",
                 i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o, exp_d);
      end
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b required 0", rsp_valid); end
    tick();
    checks++; if (stb_cycles - s0 != 2) begin errors++; $display("FAIL bp_ignored_cmds: got stb=%0d required 2", stb_cycles - s0); end
  endtask

  task automatic run_late_ack(input int late);
    int s0, lat, exp_len;
    logic        exp_err;
    logic [31:0] exp_d;
    logic [3:0]  idx;
    mode = 3;
    ack_at = late;
    rsp_ready = 1'b1;
    idx = 4'($urandom_range(0, 15));
    exp_len = late + 1;
    exp_err = 1'b0;
    exp_d = model_mem[idx];
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
    if (exp_len > T_CYC) begin
      exp_len = T_CYC;
      exp_err = 1'b1;
      exp_d = 32'h0;
    end
`endif
    s0 = stb_cycles;
    issue(1'b0, idx, 32'h0, 4'hF);
    wait_rsp(200, lat);
    checks++;
    if (rsp_err !== exp_err || rsp_dat !== exp_d) begin
      errors++;
      $display("FAIL late_ack_rsp(%0d): got err=%b dat=%h required %b/%h", late, rsp_err, rsp_dat, exp_err, exp_d);
    end
    tick();
    checks++;
    if (stb_cycles - s0 != exp_len) begin
      errors++;
      $display("FAIL late_ack_stb_len(%0d): got %0d required %0d", late, stb_cycles - s0, exp_len);
    end
    ack_at = 1000;
  endtask

  task automatic test_timeout;
`ifdef WB_SINGLE_MASTER_TIMEOUT_EN
    run_late_ack(1000);
    run_late_ack(T_CYC - 1);
    run_late_ack(T_CYC - 2);
`else
    run_late_ack(30);
`endif
  endtask

  task automatic test_reset_mid_bus;
    int a0, seen;
    mode = 3;
    ack_at = 1000;
    rsp_ready = 1'b1;
    a0 = ack_count;
    issue(1'b0, 4'd2, 32'h0, 4'hF);
    tick();
    checks++; if (wbm_stb_o !== 1'b1) begin errors++; $display("FAIL rst_mid_pre_stb: got %b required 1", wbm_stb_o); end
    reset = 1'b1;
    tick();
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, rsp_err} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_mid_state: got cyc,stb,rsp_valid,cmd_ready,err=%b required 00010",
               {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, rsp_err});
    end
    reset = 1'b0;
    mode = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid === 1'b1 || wbm_stb_o === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d active cycles required 0", seen); end
    checks++; if (ack_count != a0) begin errors++; $display("FAIL rst_mid_no_ack: got %0d acks required 0", ack_count - a0); end
  endtask

  task automatic test_random;
    int lat, hold;
    logic        we;
    logic [3:0]  idx, sel;
    logic [31:0] dat, exp_d;
    for (int n = 0; n < 16; n++) begin
      mode = $urandom_range(0, 1);
      we = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      sel = 4'($urandom_range(0, 15));
      dat = $urandom;
      if (we) begin
        model_mem[idx] = merge(model_mem[idx], dat, sel);
        exp_d = 32'h0;
      end else begin
        exp_d = model_mem[idx];
      end
      hold = $urandom_range(0, 3);
      rsp_ready = 1'b0;
      issue(we, idx, dat, sel);
      wait_rsp(10, lat);
      repeat (hold) tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== exp_d || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d]: got valid=%b dat=%h err=%b required 1/%h/0", n, rsp_valid, rsp_dat, rsp_err, exp_d);
      end
      rsp_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic        we_a [4];
    logic [3:0]  idx_a[4];
    logic [3:0]  sel_a[4];
    logic [31:0] dat_a[4];
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic        acc;
    int n_acc, n_rsp, last_acc, t;
    for (int i = 0; i < 4; i++) begin
      we_a[i]  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      idx_a[i] = (i == 1) ? idx_a[0] : 4'($urandom_range(0, 15));
      sel_a[i] = 4'($urandom_range(1, 15));
      dat_a[i] = $urandom;
    end
    mode = 0;
    rsp_ready = 1'b1;
    n_acc = 0; n_rsp = 0; last_acc = 0; t = 0;
    cmd_we = we_a[0]; cmd_adr = 32'h3000_0000 | {26'd0, idx_a[0], 2'b00};
    cmd_dat = dat_a[0]; cmd_sel = sel_a[0];
    cmd_valid = 1'b1;
    while (n_rsp < 4 && t < 60) begin
      acc = cmd_valid && cmd_ready;
      tick();
      t++;
      if (acc) begin
        if (we_a[n_acc]) begin
          model_mem[idx_a[n_acc]] = merge(model_mem[idx_a[n_acc]], dat_a[n_acc], sel_a[n_acc]);
          exp_q.push_back(32'h0);
        end else begin
          exp_q.push_back(model_mem[idx_a[n_acc]]);
        end
        if (n_acc > 0) begin
          checks++;
          if (t - last_acc != 3) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d cycles required 3", n_acc, t - last_acc); end
        end
        last_acc = t;
        n_acc++;
        if (n_acc < 4) begin
          cmd_we = we_a[n_acc]; cmd_adr = 32'h3000_0000 | {26'd0, idx_a[n_acc], 2'b00};
          cmd_dat = dat_a[n_acc]; cmd_sel = sel_a[n_acc];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (rsp_valid === 1'b1) begin
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        if (rsp_dat !== e || rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_rsp[%0d]: got dat=%h err=%b required %h/0", n_rsp, rsp_dat, rsp_err, e);
        end
        n_rsp++;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (n_rsp != 4) begin errors++; $display("FAIL b2b_count: got %0d responses required 4", n_rsp); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    mem_load = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
    init_mem[4] = 32'hCAFE_F00D;
    for (int i = 0; i < 16; i++) model_mem[i] = init_mem[i];

    test_reset();
    test_write_zero_wait();
    test_read_registered();
    test_backpressure();
    test_timeout();
    test_reset_mid_bus();
    test_random();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
